trig_pulse_gen: RTL
===================

# trig_pulse_gen

Transmit-side companion to the receive edge detector: converts single-cycle trigger strobes into clean, width-guaranteed pulses that a slower or asynchronous receiver can synchronize and edge-detect. Each accepted trigger produces one high phase of fixed width followed by a mandatory low guard gap, so back-to-back triggers never merge into one level. Optionally queues triggers that arrive while a pulse is in flight and replays them in order. Sits at the output of trigger/sequencer logic, driving cross-domain or off-chip trigger lines.

## Interface
- HIGH_CYCLES, 4, clk cycles `sig_out` is held high per pulse; must be ≥1. Size to at least 3 receiver clock periods.
- LOW_CYCLES, 4, clk cycles `sig_out` is held low after each pulse; must be ≥1. Same sizing rule.
- PEND_W, 4, width of the pending-trigger counter; saturates at 2^PEND_W−1.

- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- trig  in  1  trigger strobe; each cycle high is one trigger request.
- ovf_clr  in  1  synchronous clear of `overflow`.
- sig_out  out  1  generated pulse line, registered.
- busy  out  1  high while state ≠ IDLE.
- pend_cnt  out  PEND_W  queued triggers not yet launched.
- overflow  out  1  sticky: a trigger was lost.

## Operation
- States: IDLE, HIGH, LOW. One down-counter, width $clog2(max(HIGH_CYCLES,LOW_CYCLES))+1.
- IDLE: `trig`=1 → HIGH, counter=HIGH_CYCLES−1, `sig_out`=1. `pend_cnt` untouched.
- HIGH: counts down; at counter 0 → LOW, counter=LOW_CYCLES−1, `sig_out`=0.
- LOW: counts down; at counter 0 ("launch point") → HIGH if `pend_cnt`>0 or `trig`=1 (launch), else IDLE.
- Pending update every cycle: `pend_cnt_next = pend_cnt + inc − dec`, where inc = `trig` and state ≠ IDLE; dec = launch at launch point.
- Launch point with `trig`=1: trigger consumed by the launch; net `pend_cnt` unchanged (whether 0 or nonzero).
- Saturation: inc with `pend_cnt` at max and no dec → trigger dropped, `overflow` set. Inc and dec in same cycle at max → unchanged, no overflow.
- `ovf_clr` clears `overflow` next edge; a same-cycle overflow event wins (stays 1).
- `trig` held high N cycles = N triggers.

## Timing
- Reset values: `sig_out`=0, `busy`=0, `pend_cnt`=0, `overflow`=0, state IDLE. Asserting `rst` mid-pulse drops `sig_out` immediately (asynchronous); queued triggers discarded.
- `trig` sampled at edge k in IDLE → `sig_out`=1 after edge k through edge k+HIGH_CYCLES−1; 0 from edge k+HIGH_CYCLES.
- Launch point is edge k+HIGH_CYCLES+LOW_CYCLES; pulse period is exactly HIGH_CYCLES+LOW_CYCLES for queued or back-to-back triggers.
- `busy` falls after the launch-point edge when nothing launches.
- No combinational path from any input to any output.

## Configuration
- `TRIG_PULSE_GEN_QUEUE_EN` defined: queuing as above.
- Undefined: no pending counter; `pend_cnt` tied 0; any `trig` while state ≠ IDLE is dropped and sets `overflow`, except `trig` at the launch point, which still launches directly.

## Test plan
- HIGH=4, LOW=4: single `trig` at edge 10 → `sig_out` high after edges 10–13, low from 14, `busy` low after edge 18, `pend_cnt` stays 0.
- Queue on, PEND_W=2: `trig` at edges 10, 11, 12 → pulses rising at edges 10, 18, 26; `pend_cnt` 1 after 11, 2 after 12, 1 after 18, 0 after 26.
- Queue on, PEND_W=2: `trig` held high edges 10–14 → `pend_cnt` saturates at 3 after edge 13, `overflow`=1 after edge 14; `ovf_clr` at edge 20 → `overflow`=0 after 20.
- `trig` exactly at launch point edge 18 with `pend_cnt`=0 → `sig_out` rises after edge 18, `pend_cnt` stays 0, `busy` never drops.
- `rst` asserted mid-HIGH with `pend_cnt`=2 → `sig_out`, `pend_cnt`, `busy` 0 immediately; next `trig` launches normally.
- Queue off: `trig` at edges 10 and 12 → one pulse only, `overflow`=1 after edge 12, `pend_cnt`=0.

Source files
------------

// File: rtl/trig_pulse_gen.sv
// Trigger-to-pulse generator: each accepted trigger makes a HIGH_CYCLES-wide pulse followed by a LOW_CYCLES guard gap.
// Define TRIG_PULSE_GEN_QUEUE_EN to queue triggers that arrive while a pulse is in flight; otherwise they are dropped.
module trig_pulse_gen #(
  parameter int HIGH_CYCLES = 4,
  parameter int LOW_CYCLES  = 4,
  parameter int PEND_W      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trig,
  input  logic              ovf_clr,
  output logic              sig_out,
  output logic              busy,
  output logic [PEND_W-1:0] pend_cnt,
  output logic              overflow
);

  localparam int MAX_CYC = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0] HIGH_LOAD = CNT_W'(HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOW_LOAD  = CNT_W'(LOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PEND_W-1:0]  pend_q, pend_d;
  logic               sig_q, sig_d;
  logic               ovf_q, ovf_d;
  logic               at_lp;
  logic               launch;
  logic               lost;

`ifdef TRIG_PULSE_GEN_QUEUE_EN
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);
  logic inc;
  logic dec;
`endif

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    launch  = 1'b0;
    at_lp   = (state_q == LOW) && (cnt_q == '0);

    case (state_q)
      IDLE: begin
        if (trig) begin
          state_d = HIGH;
          cnt_d   = HIGH_LOAD;
        end
      end
      HIGH: begin
        if (cnt_q == '0) begin
          state_d = LOW;
          cnt_d   = LOW_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      LOW: begin
        if (cnt_q == '0) begin
          // Launch point: a queued trigger or a fresh strobe starts the next pulse.
          if ((pend_q != '0) || trig) begin
            launch  = 1'b1;
            state_d = HIGH;
            cnt_d   = HIGH_LOAD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    sig_d = (state_d == HIGH);

`ifdef TRIG_PULSE_GEN_QUEUE_EN
    // A strobe at the launch point is both an increment and the consuming decrement.
    inc    = trig && (state_q != IDLE);
    dec    = launch;
    pend_d = pend_q;
    lost   = 1'b0;
    if (inc && !dec) begin
      if (&pend_q) lost = 1'b1;
      else         pend_d = pend_q + PEND_ONE;
    end else if (dec && !inc) begin
      pend_d = pend_q - PEND_ONE;
    end
`else
    pend_d = '0;
    lost   = trig && (state_q != IDLE) && !at_lp;
`endif

    // A loss in the same cycle as a clear request keeps the flag set.
    if (lost)         ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
    else              ovf_d = ovf_q;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      sig_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      sig_q   <= sig_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sig_out  = sig_q;
  assign busy     = (state_q != IDLE);
  assign pend_cnt = pend_q;
  assign overflow = ovf_q;

endmodule
